ir_pc_unit: RTL and testbench

IR_PC_UNIT -- requirements
Module: ir_pc_unit

---
 rtl/ir_pc_unit_pkg.sv | 16 +
 rtl/ir_pc_unit_if.sv | 30 +++
 rtl/ir_pc_unit_flopenr.sv | 12 +
 rtl/ir_pc_unit.sv | 50 +++++
 tb/tb_ir_pc_unit.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/ir_pc_unit_pkg.sv
// ir_pc_unit_pkg: opcodes and next-PC select encodings shared by the controller and the IR/PC unit
package ir_pc_unit_pkg;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [3:0] LANES_ALL = 4'b1111;
  typedef enum logic [1:0] {
    PC_ALURES = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_HOLD   = 2'b11
  } pcsrc_t;
endpackage

// File: rtl/ir_pc_unit_if.sv
// ir_pc_unit_if: controller/memory/ALU connections of the IR/PC unit
interface ir_pc_unit_if #(parameter int WIDTH = 8);
  logic             pcen;
  logic [1:0]       pcsource;
  logic             iord;
  logic [3:0]       irwrite;
  logic [WIDTH-1:0] memdata;
  logic [WIDTH-1:0] aluresult;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] pc;
  logic [31:0]      instr;
  logic [5:0]       op;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [5:0]       funct;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] aluout;
  logic [WIDTH-1:0] mdr;
  logic             fetch_done;
  logic             seq_err;
  modport master (
    output pcen, pcsource, iord, irwrite, memdata, aluresult,
    input  adr, pc, instr, op, rs, rt, rd, funct, imm, aluout, mdr, fetch_done, seq_err
  );
  modport slave (
    input  pcen, pcsource, iord, irwrite, memdata, aluresult,
    output adr, pc, instr, op, rs, rt, rd, funct, imm, aluout, mdr, fetch_done, seq_err
  );
endinterface

// File: rtl/ir_pc_unit_flopenr.sv
// flopenr: enabled register with synchronous active-high reset
module flopenr #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/ir_pc_unit.sv
// ir_pc_unit: program counter, byte-lane instruction register and fetch tracking
module ir_pc_unit
  import ir_pc_unit_pkg::*;
#(parameter int WIDTH = 8) (
  input logic clk,
  input logic reset,
  ir_pc_unit_if.slave bus
);
  logic [WIDTH-1:0] pc_q, pc_next, aluout_q, mdr_q;
  logic [7:0] lane [4];
  logic [3:0] lanes_seen, covered;
  logic fetch_done_q, seq_err_q;
  always_comb
    pc_next = bus.pcsource == PC_ALURES ? bus.aluresult :
              bus.pcsource == PC_ALUOUT ? aluout_q :
              bus.pcsource == PC_JUMP   ? {bus.instr[WIDTH-3:0], 2'b00} : pc_q;
  flopenr #(.WIDTH(WIDTH)) u_pc (.clk(clk), .reset(reset), .en(bus.pcen), .d(pc_next), .q(pc_q));
  for (genvar i = 0; i < 4; i++) begin : g_lane
    flopenr #(.WIDTH(8)) u_lane (.clk(clk), .reset(reset), .en(bus.irwrite[i]), .d(bus.memdata[7:0]), .q(lane[i]));
  end
  assign covered = lanes_seen | bus.irwrite;
  // a lane written this cycle that completes coverage closes the fetch
  always_ff @(posedge clk)
    if (reset) begin
      aluout_q     <= '0;
      mdr_q        <= '0;
      lanes_seen   <= '0;
      fetch_done_q <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      aluout_q     <= bus.aluresult;
      mdr_q        <= bus.memdata;
      lanes_seen   <= covered == LANES_ALL ? 4'b0000 : covered;
      fetch_done_q <= covered == LANES_ALL;
      seq_err_q    <= seq_err_q | (|(bus.irwrite & lanes_seen));
    end
  assign bus.pc         = pc_q;
  assign bus.aluout     = aluout_q;
  assign bus.mdr        = mdr_q;
  assign bus.adr        = bus.iord ? aluout_q : pc_q;
  assign bus.instr      = {lane[3], lane[2], lane[1], lane[0]};
  assign bus.op         = bus.instr[31:26];
  assign bus.rs         = bus.instr[25:21];
  assign bus.rt         = bus.instr[20:16];
  assign bus.rd         = bus.instr[15:11];
  assign bus.funct      = bus.instr[5:0];
  assign bus.imm        = bus.instr[WIDTH-1:0];
  assign bus.fetch_done = fetch_done_q;
  assign bus.seq_err    = seq_err_q;
endmodule

// File: tb/tb_ir_pc_unit.sv
// tb_ir_pc_unit: directed vectors against a cycle-level behavioural model of the IR/PC unit
module tb_ir_pc_unit;
  import ir_pc_unit_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int n_checks = 0;
  int n_fail = 0;
  bit started = 0;
  ir_pc_unit_if #(.WIDTH(8)) bus ();
  ir_pc_unit #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0]  m_pc, m_alu, m_mdr;
  logic [7:0]  m_byte [4];
  logic [3:0]  m_seen;
  logic        m_done, m_err;
  logic [31:0] m_instr;
  assign m_instr = {m_byte[3], m_byte[2], m_byte[1], m_byte[0]};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (reset) begin
      m_pc = 0; m_alu = 0; m_mdr = 0; m_seen = 0; m_done = 0; m_err = 0;
      for (int i = 0; i < 4; i++) m_byte[i] = 0;
    end else begin
      if (bus.pcen)
        case (bus.pcsource)
          2'd0: m_pc = bus.aluresult;
          2'd1: m_pc = m_alu;
          2'd2: m_pc = 8'(m_instr * 4);
          default: ;
        endcase
      m_alu = bus.aluresult;
      m_mdr = bus.memdata;
      m_err = m_err || ((bus.irwrite & m_seen) != 0);
      for (int i = 0; i < 4; i++) if (bus.irwrite[i]) m_byte[i] = bus.memdata;
      m_seen = m_seen | bus.irwrite;
      m_done = (m_seen == 4'hF);
      if (m_done) m_seen = 0;
    end
  end
  always @(negedge clk) if (started) begin
    chk("pc", bus.pc, m_pc);
    chk("adr", bus.adr, bus.iord ? m_alu : m_pc);
    chk("instr", bus.instr, m_instr);
    chk("op", bus.op, m_instr[31:26]);
    chk("rs", bus.rs, m_instr[25:21]);
    chk("rt", bus.rt, m_instr[20:16]);
    chk("rd", bus.rd, m_instr[15:11]);
    chk("funct", bus.funct, m_instr[5:0]);
    chk("imm", bus.imm, m_instr[7:0]);
    chk("aluout", bus.aluout, m_alu);
    chk("mdr", bus.mdr, m_mdr);
    chk("fetch_done", bus.fetch_done, m_done);
    chk("seq_err", bus.seq_err, m_err);
  end
  task automatic cyc(input logic pe, input logic [1:0] ps, input logic io, input logic [3:0] iw,
                     input logic [7:0] md, input logic [7:0] ar);
    bus.pcen = pe; bus.pcsource = ps; bus.iord = io; bus.irwrite = iw;
    bus.memdata = md; bus.aluresult = ar;
    @(posedge clk);
    #1;
  endtask
  task automatic rst_cyc();
    reset = 1'b1;
    cyc(1'b1, 2'd0, 1'b0, 4'hF, 8'hAA, 8'h11);
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    bus.pcen = 0; bus.pcsource = 0; bus.iord = 0; bus.irwrite = 0; bus.memdata = 0; bus.aluresult = 0;
    repeat (2) @(posedge clk);
    #1;
    started = 1;
    chk("rst_pc", bus.pc, 8'h00);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_done", bus.fetch_done, 1'b0);
    chk("rst_err", bus.seq_err, 1'b0);
    reset = 1'b0;
    cyc(0, 0, 0, 4'h1, 8'h44, 0);
    cyc(0, 0, 0, 4'h2, 8'h00, 0);
    cyc(0, 0, 0, 4'h4, 8'h03, 0);
    chk("done_early", bus.fetch_done, 1'b0);
    cyc(0, 0, 0, 4'h8, 8'h80, 0);
    chk("fetch_instr", bus.instr, 32'h80030044);
    chk("fetch_op", bus.op, OP_LB);
    chk("fetch_done", bus.fetch_done, 1'b1);
    cyc(0, 0, 0, 4'h0, 8'h00, 0);
    chk("done_pulse", bus.fetch_done, 1'b0);
    cyc(1, 2'd0, 0, 0, 0, 8'h04);
    chk("pc_alures", bus.pc, 8'h04);
    cyc(0, 2'd0, 0, 0, 0, 8'h55);
    chk("pc_hold_en0", bus.pc, 8'h04);
    cyc(0, 0, 0, 4'h1, 8'h05, 0);
    chk("funct_05", bus.funct, 6'b000101);
    cyc(1, 2'd2, 0, 0, 0, 0);
    chk("pc_jump", bus.pc, 8'h14);
    cyc(0, 0, 0, 0, 0, 8'h3C);
    bus.iord = 1'b1;
    #1 chk("adr_aluout", bus.adr, 8'h3C);
    bus.iord = 1'b0;
    #1 chk("adr_pc", bus.adr, 8'h14);
    cyc(1, 2'd3, 0, 0, 0, 8'h99);
    chk("pc_hold_11", bus.pc, 8'h14);
    cyc(1, 2'd1, 0, 0, 0, 8'h77);
    chk("pc_aluout", bus.pc, 8'h99);
    rst_cyc();
    chk("rst_ovr_pc", bus.pc, 8'h00);
    chk("rst_ovr_instr", bus.instr, 32'h0);
    cyc(0, 0, 0, 4'h1, 8'h11, 0);
    cyc(0, 0, 0, 4'h2, 8'h22, 0);
    rst_cyc();
    chk("mid_rst_instr", bus.instr, 32'h0);
    chk("mid_rst_done", bus.fetch_done, 1'b0);
    cyc(0, 0, 0, 4'h4, 8'h33, 0);
    cyc(0, 0, 0, 4'h8, 8'h44, 0);
    chk("partial_discarded", bus.fetch_done, 1'b0);
    cyc(0, 0, 0, 4'h1, 8'h55, 0);
    cyc(0, 0, 0, 4'h2, 8'h66, 0);
    chk("any_order_done", bus.fetch_done, 1'b1);
    chk("any_order_instr", bus.instr, 32'h44336655);
    cyc(0, 0, 0, 4'h1, 8'h01, 0);
    chk("err_clear", bus.seq_err, 1'b0);
    cyc(0, 0, 0, 4'h1, 8'h02, 0);
    chk("err_set", bus.seq_err, 1'b1);
    chk("err_lane_loads", bus.instr[7:0], 8'h02);
    cyc(0, 0, 0, 4'h0, 8'h00, 0);
    chk("err_sticky", bus.seq_err, 1'b1);
    rst_cyc();
    chk("err_rst", bus.seq_err, 1'b0);
    cyc(0, 0, 0, 4'hF, 8'h01, 0);
    chk("multi_instr", bus.instr, 32'h01010101);
    chk("multi_done", bus.fetch_done, 1'b1);
    cyc(1, 2'd2, 0, 4'hF, 8'hFF, 0);
    chk("same_cycle_pc", bus.pc, 8'h04);
    chk("same_cycle_instr", bus.instr, 32'hFFFFFFFF);
    chk("same_cycle_err", bus.seq_err, 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
